// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial N-bit subtract sequencer built around one 1-bit full subtractor

// sub_1b - 1-bit full subtractor cell: d = a - b - b_in, b_out = borrow out
module sub_1b (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    // Difference and borrow of a single bit position
    always_comb begin
        d     = a ^ b ^ b_in;
        b_out = (~a & b) | (~(a ^ b) & b_in);
    end

endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             init_done;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic             zacc;
    logic [CNT_W-1:0] cnt;
    logic             sa;
    logic             sb;
    logic             cell_d;
    logic             cell_bout;
    logic             accept;

    sub_1b u_cell (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .b_in  (brw),
        .d     (cell_d),
        .b_out (cell_bout)
    );

    // in_ready waits for init_done so it stays low through reset and rises one cycle after release
    assign in_ready  = (state == IDLE) & init_done;
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; flush overrides accept and out_ready
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = RUN;
                RUN:     if (cnt == LAST) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand load, serial subtract step, and result capture on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            brw       <= 1'b0;
            zacc      <= 1'b0;
            cnt       <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            a_sh <= a;
                            b_sh <= b;
                            brw  <= 1'b0;
                            cnt  <= '0;
                            res  <= '0;
                            zacc <= 1'b0;
                            sa   <= a[WIDTH-1];
                            sb   <= b[WIDTH-1];
                        end
                    end
                    RUN: begin
                        res  <= {cell_d, res[WIDTH-1:1]};
                        a_sh <= a_sh >> 1;
                        b_sh <= b_sh >> 1;
                        brw  <= cell_bout;
                        zacc <= zacc | cell_d;
                        if (cnt == LAST) begin
                            // cell_d is the result MSB on this step
                            diff   <= {cell_d, res[WIDTH-1:1]};
                            borrow <= cell_bout;
                            zero   <= ~(zacc | cell_d);
                            ovf    <= (sa != sb) & (cell_d != sa);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed self-checking bench for serial_sub_ctrl
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present operands for one accept edge
    task automatic accept(input logic [7:0] av, input logic [7:0] bv);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", in_ready, 1'b1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid; in_ready must stay low throughout
    task automatic wait_valid(output int cycles);
        logic rdy_seen = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            cycles++;
        end
        check("in_ready_run", rdy_seen, 1'b0);
        check("in_ready_done", in_ready, 1'b0);
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic ez, input logic eo);
        int cyc;
        accept(av, bv);
        wait_valid(cyc);
        check("latency", cyc, 8);
        check("diff", diff, ed);
        check("borrow", borrow, eb);
        check("zero", zero, ez);
        check("ovf", ovf, eo);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready", in_ready, 1'b1);
        check("idle_valid", out_valid, 1'b0);
    endtask

    initial begin
        int cyc;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outs", {diff, borrow, zero, ovf}, 11'h0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", in_ready, 1'b1);

        // Basic and boundary subtractions
        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
        do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
        do_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure and ignored in_valid during RUN/DONE
        accept(8'h5A, 8'h23);
        a = 8'h11;
        b = 8'h99;
        in_valid = 1'b1;
        wait_valid(cyc);
        check("bp_latency", cyc, 8);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_valid", out_valid, 1'b1);
            check("bp_diff", diff, 8'h37);
        end
        check("bp_flags", {borrow, zero, ovf}, 3'b000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", in_ready, 1'b1);

        // Async reset mid-RUN clears outputs, no result emitted
        accept(8'h33, 8'h11);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("arst_outs", {out_valid, diff, borrow, zero, ovf}, 12'h0);
        check("arst_ready", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

        // Flush in RUN when cnt==3
        accept(8'h09, 8'h02);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_run_ready", in_ready, 1'b1);
        check("flush_run_diff", diff, 8'h0F);
        begin
            logic v = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (out_valid) v = 1'b1;
                tick();
            end
            check("flush_no_valid", v, 1'b0);
        end

        // Flush with in_valid in IDLE: no accept
        a = 8'h44;
        b = 8'h01;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_ready", in_ready, 1'b1);
        repeat (9) tick();
        check("flush_idle_valid", out_valid, 1'b0);

        // Flush in DONE with out_ready: IDLE, outputs retained
        accept(8'h01, 8'h02);
        wait_valid(cyc);
        check("fd_diff", diff, 8'hFF);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        check("fd_ready", in_ready, 1'b1);
        check("fd_valid", out_valid, 1'b0);
        check("fd_hold", {diff, borrow, zero, ovf}, {8'hFF, 3'b100});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtract sequencer. It time-multiplexes one instance of the codebase's 1-bit full subtractor cell (sub_1b) to compute an N-bit A − B, LSB first, one bit per clock. A registered borrow loop carries the borrow between bits. The block provides a low-area subtract/compare service to the ALU, with valid/ready handshakes on both the input and the output side.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; returns block to IDLE
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a − b modulo 2^WIDTH
borrow  output  1  final borrow; 1 iff unsigned a < b
zero  output  1  diff == 0
ovf  output  1  signed two's-complement overflow of a − b

Behaviour:
- Reset: clk and rst_n form one clock domain; rst_n is asynchronous and active-low.
- rst_n low forces state IDLE and clears all registers: shift regs, result, borrow, count, zero, ovf and sign captures. In reset, in_ready=0, out_valid=0, diff=0, borrow=0, zero=0, ovf=0. in_ready rises in the first cycle after rst_n deasserts.
- FSM states: IDLE, RUN, DONE. Outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- IDLE: in_ready=1.
  - in_valid&in_ready at an edge: load a_sh<=a, b_sh<=b, brw<=0, cnt<=0, res<=0, zacc<=0, capture sa=a[W-1] and sb=b[W-1]; go to RUN.
  - diff/borrow/zero/ovf keep their last completed values.
- RUN: in_ready=0, out_valid=0; in_valid is ignored. Each edge:
  - cell inputs are A=a_sh[0], B=b_sh[0], b_in=brw;
  - res <= {cell diff, res[W-1:1]};
  - a_sh and b_sh shift right one bit;
  - brw <= cell b_out;
  - zacc <= zacc | cell diff;
  - cnt++.
  - On the edge where cnt==WIDTH-1, go to DONE. RUN therefore lasts exactly WIDTH cycles.
- DONE entry (same edge as the last RUN step):
  - diff <= final res;
  - borrow <= final b_out;
  - zero <= ~(zacc | last diff bit);
  - ovf <= (sa != sb) & (diff[W-1] != sa), using the final MSB.
- DONE: out_valid=1, and all result outputs are held stable while out_ready=0 (unbounded backpressure). When out_valid&out_ready at an edge, go to IDLE; the next accept can occur no earlier than the following edge.
- Latency: out_valid rises exactly WIDTH clocks after the accept edge. Throughput is one operation per WIDTH+2 cycles minimum.
- flush=1 at an edge: go to IDLE from any state. The in-flight operation is discarded and produces no out_valid. Result outputs keep their prior completed values. flush has priority over an accept and over out_ready in the same cycle.
- rst_n asserted mid-RUN or mid-DONE: immediate return to reset values and no result is emitted; cnt restarts from 0 on the next operation.
- Width rule: cnt saturates logically at WIDTH-1 and never wraps inside RUN. Operands are unsigned for borrow and two's complement for ovf.

Test Plan:
1. Reset, then a=0x05, b=0x03 accepted (WIDTH=8) -> out_valid exactly 8 clocks later; diff=0x02, borrow=0, zero=0, ovf=0; in_ready=0 throughout RUN/DONE.
2. a=0x03, b=0x05 -> diff=0xFE, borrow=1, zero=0, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
3. a=0xA5, b=0xA5 -> diff=0x00, zero=1, borrow=0. Then a=0x00, b=0x00 -> zero=1.
4. Hold out_ready=0 for 6 cycles in DONE -> out_valid and diff remain stable. Pulse in_valid with new operands during RUN and DONE -> both are ignored and the result is unchanged. out_ready=1 -> IDLE next cycle, in_ready=1.
5. Drop rst_n 4 cycles into RUN -> outputs go to 0 asynchronously with no out_valid. After release, a=0x10, b=0x01 -> diff=0x0F after exactly 8 cycles.
6. Assert flush in the cycle where cnt==3 -> IDLE next cycle with no out_valid. Assert flush together with in_valid in IDLE -> no accept. Assert flush in DONE together with out_ready=1 -> IDLE, and the prior completed outputs are retained.
